// File: rtl/touch_sample_sequencer.sv
// Debounces touch/release, averages 2**AVG_LOG2 samples, publishes only on frame_start; TOUCH_SEQ_JUMP_REJECT_EN adds outlier rejection.
// Latency: out_x/out_y/out_valid change and out_update pulses on the cycle after frame_start.
// No backpressure: every sample_valid is consumed; averages overwritten before publish are counted in drop_count.
module touch_sample_sequencer #(
  parameter int COORD_W        = 12,
  parameter int AVG_LOG2       = 2,
  parameter int DEBOUNCE       = 3,
  parameter int TIMEOUT_CYCLES = 6500000,
  parameter int JUMP_LIMIT     = 256
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sample_valid,
  input  logic [COORD_W-1:0] x_in,
  input  logic [COORD_W-1:0] y_in,
  input  logic               touched_in,
  input  logic               frame_start,
  output logic [COORD_W-1:0] out_x,
  output logic [COORD_W-1:0] out_y,
  output logic               out_valid,
  output logic               out_update,
  output logic               stale,
  output logic [7:0]         drop_count
);

  localparam int ACC_W = COORD_W + AVG_LOG2;
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ARM   = 2'd1;
  localparam logic [1:0] ACCUM = 2'd2;

  localparam logic [3:0]        DEB_LAST = 4'(DEBOUNCE - 1);
  localparam logic [AVG_LOG2:0] N_LAST   = (AVG_LOG2 + 1)'((1 << AVG_LOG2) - 1);
  localparam logic [WD_W-1:0]   WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WD_W-1:0]   WD_MAX   = WD_W'(TIMEOUT_CYCLES);

  logic [1:0]         state;
  logic [3:0]         deb_cnt;
  logic [3:0]         rel_cnt;
  logic [ACC_W-1:0]   acc_x, acc_y;
  logic [AVG_LOG2:0]  n;
  logic [COORD_W-1:0] pend_x, pend_y;
  logic               pending, pending_release;
  logic [WD_W-1:0]    wd_cnt;

  logic             samp_t, samp_u, in_accum, reject;
  logic             accept, rejected, avg_done;
  logic             wd_expire, rel_by_touch, release_now;
  logic             publish_rel, publish_pend, drop_inc;
  logic [ACC_W-1:0] sum_x, sum_y;

  assign samp_t   = sample_valid & touched_in;
  assign samp_u   = sample_valid & ~touched_in;
  assign in_accum = (state == ACCUM);

`ifdef TOUCH_SEQ_JUMP_REJECT_EN
  // Distance is measured against the currently published point, so rejection only applies while a touch is shown.
  logic [31:0] dx, dy;
  assign dx = (x_in > out_x) ? 32'(x_in) - 32'(out_x) : 32'(out_x) - 32'(x_in);
  assign dy = (y_in > out_y) ? 32'(y_in) - 32'(out_y) : 32'(out_y) - 32'(y_in);
  assign reject = out_valid & ((dx > 32'(JUMP_LIMIT)) | (dy > 32'(JUMP_LIMIT)));
`else
  logic unused_jump;
  assign unused_jump = ^32'(JUMP_LIMIT);
  assign reject = 1'b0;
`endif

  assign accept       = in_accum & samp_t & ~reject;
  assign rejected     = in_accum & samp_t & reject;
  assign avg_done     = accept & (n == N_LAST);
  assign sum_x        = acc_x + ACC_W'(x_in);
  assign sum_y        = acc_y + ACC_W'(y_in);

  // A sample in the expiry cycle wins, so expiry only fires on a quiet cycle.
  assign wd_expire    = ~sample_valid & (wd_cnt == WD_LAST);
  assign rel_by_touch = in_accum & samp_u & (rel_cnt == DEB_LAST);
  assign release_now  = rel_by_touch | (wd_expire & (state != IDLE));

  assign publish_rel  = frame_start & pending_release;
  assign publish_pend = frame_start & ~pending_release & pending;
  assign drop_inc     = rejected | (avg_done & pending & ~publish_pend);

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      deb_cnt         <= '0;
      rel_cnt         <= '0;
      acc_x           <= '0;
      acc_y           <= '0;
      n               <= '0;
      pend_x          <= '0;
      pend_y          <= '0;
      pending         <= 1'b0;
      pending_release <= 1'b0;
      wd_cnt          <= '0;
      stale           <= 1'b0;
      out_x           <= '0;
      out_y           <= '0;
      out_valid       <= 1'b0;
      out_update      <= 1'b0;
      drop_count      <= '0;
    end else begin
      if (sample_valid) begin
        wd_cnt <= '0;
        stale  <= 1'b0;
      end else if (wd_cnt != WD_MAX) begin
        wd_cnt <= wd_cnt + WD_W'(1);
      end
      if (wd_expire) stale <= 1'b1;

      case (state)
        IDLE: begin
          if (samp_t) begin
            if (DEBOUNCE == 1) begin
              state   <= ACCUM;
              acc_x   <= '0;
              acc_y   <= '0;
              n       <= '0;
              rel_cnt <= '0;
            end else begin
              state   <= ARM;
              deb_cnt <= 4'd1;
            end
          end
        end
        ARM: begin
          if (samp_t) begin
            if (deb_cnt == DEB_LAST) begin
              state   <= ACCUM;
              acc_x   <= '0;
              acc_y   <= '0;
              n       <= '0;
              rel_cnt <= '0;
            end else begin
              deb_cnt <= deb_cnt + 4'd1;
            end
          end else if (samp_u) begin
            state <= IDLE;
          end
        end
        ACCUM: begin
          if (accept) begin
            rel_cnt <= '0;
            if (avg_done) begin
              pend_x <= sum_x[ACC_W-1:AVG_LOG2];
              pend_y <= sum_y[ACC_W-1:AVG_LOG2];
              acc_x  <= '0;
              acc_y  <= '0;
              n      <= '0;
            end else begin
              acc_x <= sum_x;
              acc_y <= sum_y;
              n     <= n + (AVG_LOG2 + 1)'(1);
            end
          end else if (samp_u) begin
            rel_cnt <= rel_cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase

      if (release_now) begin
        state   <= IDLE;
        acc_x   <= '0;
        acc_y   <= '0;
        n       <= '0;
        rel_cnt <= '0;
        deb_cnt <= '0;
      end

      // A freshly completed average always waits for the next frame, even if this frame_start clears the old one.
      if (release_now)       pending <= 1'b0;
      else if (avg_done)     pending <= 1'b1;
      else if (publish_pend) pending <= 1'b0;

      if (release_now)      pending_release <= 1'b1;
      else if (frame_start) pending_release <= 1'b0;

      out_update <= publish_rel | publish_pend;
      if (publish_rel) begin
        out_valid <= 1'b0;
      end else if (publish_pend) begin
        out_x     <= pend_x;
        out_y     <= pend_y;
        out_valid <= 1'b1;
      end

      if (drop_inc && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_touch_sample_sequencer.sv
// Scoreboard bench for touch_sample_sequencer: expected publishes queued by stimulus, popped on each out_update.
module tb_touch_sample_sequencer;

  localparam int CW = 12;

  typedef struct packed {
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          v;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sample_valid = 1'b0;
  logic [CW-1:0] x_in = '0;
  logic [CW-1:0] y_in = '0;
  logic          touched_in = 1'b0;
  logic          frame_start = 1'b0;
  logic [CW-1:0] out_x, out_y;
  logic          out_valid, out_update, stale;
  logic [7:0]    drop_count;

  int tests = 0;
  int fails = 0;
  exp_t q[$];

  touch_sample_sequencer #(
    .COORD_W(CW), .AVG_LOG2(2), .DEBOUNCE(3), .TIMEOUT_CYCLES(1000), .JUMP_LIMIT(256)
  ) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .x_in(x_in), .y_in(y_in),
    .touched_in(touched_in), .frame_start(frame_start), .out_x(out_x), .out_y(out_y),
    .out_valid(out_valid), .out_update(out_update), .stale(stale), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (out_update) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_update: got out_update=1, expected no publish (x=%0d y=%0d v=%0d)",
                 out_x, out_y, out_valid);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("pub_x", int'(out_x), int'(e.x));
        check("pub_y", int'(out_y), int'(e.y));
        check("pub_valid", int'(out_valid), int'(e.v));
      end
    end
  end

  task automatic send(input logic t, input int x, input int y, input logic fs, input int gap);
    @(negedge clk);
    sample_valid = 1'b1;
    touched_in   = t;
    x_in         = x[CW-1:0];
    y_in         = y[CW-1:0];
    frame_start  = fs;
    @(negedge clk);
    sample_valid = 1'b0;
    frame_start  = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic frame();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic push(input int x, input int y, input logic v);
    exp_t e;
    e.x = x[CW-1:0];
    e.y = y[CW-1:0];
    e.v = v;
    q.push_back(e);
  endtask

  task automatic debounce_in();
    for (int i = 0; i < 3; i++) send(1'b1, 0, 0, 1'b0, 1);
  endtask

  task automatic quad(input int x0, input int x1, input int x2, input int x3, input int y);
    send(1'b1, x0, y, 1'b0, 1);
    send(1'b1, x1, y, 1'b0, 1);
    send(1'b1, x2, y, 1'b0, 1);
    send(1'b1, x3, y, 1'b0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_out_x", int'(out_x), 0);
    check("rst_out_y", int'(out_y), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_update", int'(out_update), 0);
    check("rst_stale", int'(stale), 0);
    check("rst_drop", int'(drop_count), 0);
    rst = 1'b0;

    // Basic average: (100+102+104+106)/4=103, (200..203)/4=201
    debounce_in();
    send(1'b1, 100, 200, 1'b0, 1);
    send(1'b1, 102, 201, 1'b0, 1);
    send(1'b1, 104, 202, 1'b0, 1);
    send(1'b1, 106, 203, 1'b0, 1);
    push(103, 201, 1'b1);
    frame();

    // Release after 3 untouched samples: valid drops, coordinates hold
    for (int i = 0; i < 3; i++) send(1'b0, 0, 0, 1'b0, 1);
    push(103, 201, 1'b0);
    frame();

    // Broken debounce restarts from IDLE: only one sample lands in ACCUM, nothing publishes
    send(1'b1, 0, 0, 1'b0, 1);
    send(1'b1, 0, 0, 1'b0, 1);
    send(1'b0, 0, 0, 1'b0, 1);
    quad(40, 40, 40, 40, 40);
    frame();
    check("restart_out_valid", int'(out_valid), 0);
    for (int i = 0; i < 3; i++) send(1'b0, 0, 0, 1'b0, 1);
    push(103, 201, 1'b0);
    frame();

    // Two averages without a frame: first is dropped, second (241/4=60) publishes
    debounce_in();
    quad(48, 50, 52, 50, 55);
    quad(58, 60, 62, 61, 65);
    check("drop_after_overwrite", int'(drop_count), 1);
    push(60, 65, 1'b1);
    frame();

    // Average completing on frame_start with nothing pending waits a frame
    send(1'b1, 70, 75, 1'b0, 1);
    send(1'b1, 70, 75, 1'b0, 1);
    send(1'b1, 70, 75, 1'b0, 1);
    send(1'b1, 70, 75, 1'b1, 3);
    push(70, 75, 1'b1);
    frame();

    // Completion on frame_start with a pending average: old publishes, new waits, no drop
    quad(80, 80, 80, 80, 85);
    send(1'b1, 90, 95, 1'b0, 1);
    send(1'b1, 90, 95, 1'b0, 1);
    send(1'b1, 90, 95, 1'b0, 1);
    push(80, 85, 1'b1);
    send(1'b1, 90, 95, 1'b1, 3);
    check("no_drop_when_cleared", int'(drop_count), 1);
    push(90, 95, 1'b1);
    frame();

    // Watchdog: stale exactly 1000 cycles after the last sample
    send(1'b1, 91, 96, 1'b0, 0);
    repeat (999) @(negedge clk);
    check("stale_before_timeout", int'(stale), 0);
    @(negedge clk);
    check("stale_at_timeout", int'(stale), 1);
    check("valid_held_until_frame", int'(out_valid), 1);
    push(90, 95, 1'b0);
    frame();
    check("stale_held", int'(stale), 1);
    send(1'b0, 0, 0, 1'b0, 0);
    check("stale_cleared", int'(stale), 0);

    // Reset mid-ACCUM discards the partial sum; fresh average (10+12+14+16)/4=13
    debounce_in();
    send(1'b1, 500, 500, 1'b0, 1);
    send(1'b1, 500, 500, 1'b0, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_out_x", int'(out_x), 0);
    check("midrst_out_y", int'(out_y), 0);
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_drop", int'(drop_count), 0);
    debounce_in();
    quad(10, 12, 14, 16, 20);
    push(13, 20, 1'b1);
    frame();

`ifdef TOUCH_SEQ_JUMP_REJECT_EN
    // Outlier far from published 13 is discarded and counted; following average excludes it
    send(1'b1, 500, 20, 1'b0, 1);
    check("jump_drop", int'(drop_count), 1);
    quad(20, 20, 20, 20, 20);
    push(20, 20, 1'b1);
    frame();
`endif

    repeat (5) @(negedge clk);
    check("scoreboard_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/touch_sample_sequencer.md
Name: touch_sample_sequencer

Overview:
Sits between the SPI touch-panel slave and its consumers (bubble display, plate control loop). Debounces touch/release, averages 2^AVG_LOG2 coordinate samples, and publishes results only on video frame boundaries, so consumers never see coordinates change mid-frame. Also runs a sample-watchdog that forces a release when the panel stops reporting.

Parameters:
COORD_W, 12, coordinate width from the SPI slave.
AVG_LOG2, 2, log2 of samples per average (4).
DEBOUNCE, 3, consecutive samples needed to accept a touch or a release; range 1..15.
TIMEOUT_CYCLES, 6500000, clk cycles without sample_valid before forced release (100 ms at 65 MHz).
JUMP_LIMIT, 256, outlier threshold; used only with the optional feature.

Ports:
clk  in  1  system clock (65 MHz pixel clock domain).
rst  in  1  synchronous, active-high reset.
sample_valid  in  1  one-cycle strobe: x_in/y_in/touched_in hold a new sample.
x_in  in  COORD_W  sample X.
y_in  in  COORD_W  sample Y.
touched_in  in  1  panel touch status for this sample.
frame_start  in  1  one-cycle pulse at start of vertical blanking.
out_x  out  COORD_W  published X; holds its value across release.
out_y  out  COORD_W  published Y.
out_valid  out  1  high while a stable touch is published.
out_update  out  1  one-cycle pulse whenever out_x/out_y/out_valid change.
stale  out  1  watchdog expired; cleared by the next sample_valid.
drop_count  out  8  saturating count of averages overwritten before publish (plus rejects, see option).

Behaviour:
- Reset: state IDLE; all accumulators and counters 0; out_x=out_y=0; out_valid=0; out_update=0; stale=0; drop_count=0; pending and pending_release flags cleared. Reset mid-operation discards any partial average.
- States:
  - IDLE: on sample_valid & touched_in, go to ARM with deb_cnt=1. If DEBOUNCE=1, go straight to ACCUM instead.
  - ARM: on sample_valid & touched_in, increment deb_cnt; when it reaches DEBOUNCE, go to ACCUM with acc cleared. On sample_valid & !touched_in, go to IDLE.
  - ACCUM: on sample_valid & touched_in:
    - acc_x += x_in; acc_y += y_in; n++; rel_cnt=0.
    - Accumulator width is COORD_W+AVG_LOG2, so it cannot overflow.
    - When n reaches 2^AVG_LOG2: pend_x = acc_x >> AVG_LOG2 (truncating), same for Y; set pending; clear acc and n; stay in ACCUM.
    - If pending was already set, overwrite it and increment drop_count (saturates at 255).
  - ACCUM release: on sample_valid & !touched_in, rel_cnt++. Untouched samples are not accumulated. When rel_cnt reaches DEBOUNCE: go to IDLE, discard the partial sum and pending, set pending_release.
- Watchdog: a counter resets on every sample_valid. In any state other than IDLE, reaching TIMEOUT_CYCLES sets stale=1 and applies the release action (IDLE, pending_release). In IDLE the counter saturates and asserts stale only.
- Publish (registered; evaluated every cycle, independent of state):
  - On frame_start with pending_release: out_valid<=0, out_x/out_y hold, out_update=1 next cycle. Release wins over pending.
  - Else on frame_start with pending: out_x/out_y<=pend values, out_valid<=1, out_update=1 next cycle, pending cleared.
  - Else on frame_start: no change, out_update=0.
- Latency: outputs change on the cycle after frame_start is sampled; out_update is high exactly that cycle.
- Simultaneous events:
  - An average completing in the same cycle as frame_start is not published; it becomes pending for the next frame. No drop is counted if pending was cleared by that frame_start.
  - sample_valid in the same cycle as watchdog expiry: the sample wins and the watchdog restarts.

Optional Feature:
Macro TOUCH_SEQ_JUMP_REJECT_EN.
- Defined: in ACCUM while out_valid=1, a touched sample with |x_in-out_x| > JUMP_LIMIT or |y_in-out_y| > JUMP_LIMIT is discarded. It is not accumulated, does not affect rel_cnt, and increments drop_count (saturating). When out_valid=0, no sample is rejected.
- Undefined: all touched samples are accumulated and JUMP_LIMIT is unused.

Test Plan:
1. Use AVG_LOG2=2, DEBOUNCE=3. Send 3 touched samples, then X=100,102,104,106 and Y=200,201,202,203, then frame_start -> out_x=103, out_y=201, out_valid=1, out_update high one cycle after frame_start.
2. Send touched, touched, untouched, then 4 touched samples, then frame_start -> out_valid stays 0, because debounce restarts from IDLE.
3. From a valid touch, send 3 untouched samples, then frame_start -> out_valid=0, out_update pulse, out_x/out_y hold their last values.
4. Send 8 touched samples with no frame_start (averages 50, then 60) -> drop_count=1; the next frame_start publishes 60.
5. Set TIMEOUT_CYCLES=1000 in sim. Stop samples in ACCUM -> stale=1 at cycle 1000; out_valid=0 after the next frame_start; the next sample_valid clears stale.
6. Assert rst mid-ACCUM after 2 samples -> all outputs 0 next cycle; 4 fresh samples after re-debounce average without the old data. With TOUCH_SEQ_JUMP_REJECT_EN defined, out_x=103 and x_in=500 -> sample rejected, drop_count increments.
